// File: rtl/boot_pkg.sv
// Shared types and default widths for the boot-time ROM-to-RAM copier.
// Widths follow the global address/word sizes.
package boot_pkg;

    localparam int ADDR_SIZE = 8;
    localparam int WORD_SIZE = 16;

    localparam int DEF_ADDR_W = ADDR_SIZE;
    localparam int DEF_WORD_W = WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE,
        DONE
    } boot_state_t;

endpackage

// File: rtl/boot_loader.sv
// Boot image copier: walks ROM in word steps and mirrors each word into RAM,
// holding the core in reset until the image is in place.
module boot_loader
    import boot_pkg::*;
#(
    parameter int              ADDR_W    = DEF_ADDR_W,
    parameter int              WORD_W    = DEF_WORD_W,
    parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(46)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              boot,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic              ram_ready,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold
);

    // Only even word addresses are copied, so the low bit of the limit is dropped.
    localparam logic [ADDR_W-1:0] END_ADDR = {LAST_ADDR[ADDR_W-1:1], 1'b0};

    boot_state_t state;

    assign ram_addr = rom_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            boot      <= 1'b0;
            rom_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cpu_hold  <= 1'b1;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= FETCH;
                        rom_addr <= '0;
                        boot     <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                FETCH: begin
                    ram_wdata <= rom_data;
                    ram_we    <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    if (ram_ready) begin
                        ram_we <= 1'b0;
                        // Compare before incrementing so a top-of-space limit never wraps.
                        if (rom_addr == END_ADDR) begin
                            state    <= DONE;
                            boot     <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            rom_addr <= rom_addr + ADDR_W'(2);
                            state    <= FETCH;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: ROM/RAM models, copy scoreboard,
// backpressure, reset, start handling and end-address boundaries.
module tb_boot_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        boot;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic        ram_ready;
    logic        busy;
    logic        done;
    logic        cpu_hold;

    logic        b1_start, b1_boot, b1_we, b1_busy, b1_done, b1_hold;
    logic [7:0]  b1_raddr, b1_waddr;
    logic [15:0] b1_rdata, b1_wdata;
    logic        b2_start, b2_boot, b2_we, b2_busy, b2_done, b2_hold;
    logic [7:0]  b2_raddr, b2_waddr;
    logic [15:0] b2_rdata, b2_wdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [256];
    int          we_cyc [256];
    int          nwr;
    int          exp_addr;
    logic        stall_prev;
    logic [15:0] prev_wdata;
    int          b1_n, b2_n;
    int          b1_last, b2_last;

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        if (a == 8'd40) return 16'h0000;
        if (a == 8'd46) return 16'h0002;
        return {a ^ 8'hA5, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    assign rom_data = boot ? rom_word(rom_addr) : 16'hDEAD;
    assign b1_rdata = b1_boot ? rom_word(b1_raddr) : 16'hDEAD;
    assign b2_rdata = b2_boot ? rom_word(b2_raddr) : 16'hDEAD;

    boot_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .boot(boot),
        .rom_addr(rom_addr), .rom_data(rom_data), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_ready(ram_ready),
        .busy(busy), .done(done), .cpu_hold(cpu_hold)
    );

    boot_loader #(.LAST_ADDR(8'd254)) u254 (
        .clk(clk), .rst_n(rst_n), .start(b1_start), .boot(b1_boot),
        .rom_addr(b1_raddr), .rom_data(b1_rdata), .ram_addr(b1_waddr),
        .ram_wdata(b1_wdata), .ram_we(b1_we), .ram_ready(1'b1),
        .busy(b1_busy), .done(b1_done), .cpu_hold(b1_hold)
    );

    boot_loader #(.LAST_ADDR(8'd47)) u47 (
        .clk(clk), .rst_n(rst_n), .start(b2_start), .boot(b2_boot),
        .rom_addr(b2_raddr), .rom_data(b2_rdata), .ram_addr(b2_waddr),
        .ram_wdata(b2_wdata), .ram_we(b2_we), .ram_ready(1'b1),
        .busy(b2_busy), .done(b2_done), .cpu_hold(b2_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted write must be the next word of the image.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            chk("inv_addr_mirror", {31'd0, ram_addr == rom_addr}, 32'd1);
            chk("inv_flags", {29'd0, boot == busy, cpu_hold == !done,
                              !(boot && done)}, 32'd7);
            if (stall_prev) begin
                chk("stall_we_held", {31'd0, ram_we}, 32'd1);
                chk("stall_wdata", {16'd0, ram_wdata}, {16'd0, prev_wdata});
            end
            stall_prev = ram_we && !ram_ready;
            prev_wdata = ram_wdata;
            if (ram_we) begin
                we_cyc[ram_addr]++;
                if (ram_ready) begin
                    chk("wr_addr", {24'd0, ram_addr}, exp_addr);
                    chk("wr_data", {16'd0, ram_wdata},
                        {16'd0, rom_word(8'(exp_addr))});
                    ram[ram_addr] = ram_wdata;
                    exp_addr += 2;
                    nwr++;
                end
            end
            if (b1_we) begin
                chk("b254_seq", {24'd0, b1_waddr}, 2 * b1_n);
                b1_n++;
                b1_last = int'(b1_waddr);
            end
            if (b2_we) begin
                chk("b47_seq", {24'd0, b2_waddr}, 2 * b2_n);
                b2_n++;
                b2_last = int'(b2_waddr);
            end
        end
    end

    task automatic clear_log();
        nwr = 0;
        exp_addr = 0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 16'hFFFF;
            we_cyc[i] = 0;
        end
    endtask

    task automatic run_copy(input string name, input bit hold,
                            input int stall_at, input int exp_cyc);
        int cnt;
        int first_we;
        int stalls;
        clear_log();
        first_we = 0;
        stalls = 0;
        cnt = 0;
        @(posedge clk);
        #1 start = 1'b1;
        while (cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!hold) start = 1'b0;
            if (cnt == 1) chk({name, "_done_clr"}, {31'd0, done}, 32'd0);
            if (ram_we && first_we == 0) first_we = cnt;
            if (ram_we && int'(ram_addr) == stall_at && stalls < 3) begin
                ram_ready = 1'b0;
                stalls++;
            end else begin
                ram_ready = 1'b1;
            end
            if (done) break;
        end
        start = 1'b0;
        ram_ready = 1'b1;
        chk({name, "_cycles"}, cnt, exp_cyc);
        chk({name, "_boot_off"}, {31'd0, boot}, 32'd0);
        chk({name, "_hold_off"}, {31'd0, cpu_hold}, 32'd0);
        chk({name, "_nwrites"}, nwr, 24);
        chk({name, "_first_we"}, first_we, 2);
        chk({name, "_final_addr"}, {24'd0, rom_addr}, 32'd46);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        start = 1'b0;
        b1_start = 1'b0;
        b2_start = 1'b0;
        ram_ready = 1'b1;
        stall_prev = 1'b0;
        prev_wdata = '0;
        b1_n = 0; b2_n = 0; b1_last = -1; b2_last = -1;
        clear_log();
        #12;
        chk("rst_boot", {31'd0, boot}, 32'd0);
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_addr", {24'd0, rom_addr}, 32'd0);
        chk("rst_busy_wdata", {15'd0, busy, ram_wdata}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_copy("full", 1'b0, 255, 49);
        chk("ram40", {16'd0, ram[40]}, 32'h0000);
        chk("ram46", {16'd0, ram[46]}, 32'h0002);
        chk("ram12", {16'd0, ram[12]}, 32'hA90C);
        chk("ram48_untouched", {16'd0, ram[48]}, 32'hFFFF);

        run_copy("bp", 1'b0, 12, 52);
        chk("bp_we12", we_cyc[12], 4);
        chk("bp_we10", we_cyc[10], 1);
        chk("bp_we14", we_cyc[14], 1);

        run_copy("held", 1'b1, 255, 49);
        run_copy("again", 1'b0, 255, 49);
        chk("again_ram46", {16'd0, ram[46]}, 32'h0002);

        // Reset in the middle of the write to address 20.
        clear_log();
        @(posedge clk);
        #1 start = 1'b1;
        cnt = 0;
        while (cnt < 100 && !(ram_we && ram_addr == 8'd20)) begin
            @(posedge clk);
            #1 start = 1'b0;
            cnt++;
        end
        chk("mid_reached20", {31'd0, ram_we && ram_addr == 8'd20}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_async_drop", {30'd0, boot, ram_we}, 32'd0);
        chk("mid_hold", {30'd0, cpu_hold, done}, 32'd2);
        chk("mid_addr", {24'd0, rom_addr}, 32'd0);
        chk("mid_partial", nwr, 10);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_copy("restart", 1'b0, 255, 49);

        // End-address boundaries on the two extra instances.
        @(posedge clk);
        #1 begin b1_start = 1'b1; b2_start = 1'b1; end
        cnt = 0;
        while (cnt < 400 && !b1_done) begin
            @(posedge clk);
            #1 begin b1_start = 1'b0; b2_start = 1'b0; end
            cnt++;
            if (b2_done && b2_n == 24 && cnt == 49)
                chk("b47_cycles", cnt, 49);
        end
        chk("b254_cycles", cnt, 257);
        chk("b254_n", b1_n, 128);
        chk("b254_last", b1_last, 254);
        chk("b254_nowrap", {24'd0, b1_raddr}, 32'd254);
        chk("b47_n", b2_n, 24);
        chk("b47_last", b2_last, 46);
        chk("b47_done", {31'd0, b2_done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Boot-time image copier sitting between the program ROM and data RAM. On `start` it asserts `boot` so the ROM drives the shared data bus, walks the ROM from address 0 to `LAST_ADDR` in steps of 2, and writes each 16-bit word into RAM at the same address using a ready-gated write strobe. When the copy completes, it releases `boot` and raises `done` so the CPU core can leave reset-hold and begin fetching from RAM.

## Interface
Parameters:
- `ADDR_W`, 8: address width; matches the global `ADDR_SIZE`.
- `WORD_W`, 16: data word width; matches the global `WORD_SIZE`.
- `LAST_ADDR`, 8'd46: final even byte address copied (inclusive). Bit 0 is ignored.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock domain.
- `start`  in  1  level-sampled request; begins a copy when in IDLE or DONE.
- `boot`  out  1  ROM bus-drive enable; high only while a copy is in progress.
- `rom_addr`  out  ADDR_W  registered ROM read address.
- `rom_data`  in  WORD_W  shared data bus, valid while `boot`=1.
- `ram_addr`  out  ADDR_W  RAM write address, always equal to `rom_addr`.
- `ram_wdata`  out  WORD_W  captured word.
- `ram_we`  out  1  write strobe, held until `ram_ready`.
- `ram_ready`  in  1  RAM accepts the write on a cycle where `ram_we`=1 and `ram_ready`=1.
- `busy`  out  1  high in FETCH or WRITE.
- `done`  out  1  sticky completion flag.
- `cpu_hold`  out  1  high from reset until `done`; keeps the core stalled.

## Operation
- State machine: IDLE, FETCH, WRITE, DONE.
  - **IDLE**: `start`=1 → FETCH, with `rom_addr` cleared to 0.
  - **FETCH**: `boot`=1. `rom_data` is latched into `ram_wdata` at the end of the cycle → WRITE.
  - **WRITE**: `boot`=1 and `ram_we`=1. The state holds while `ram_ready`=0. On `ram_ready`=1:
    - if `rom_addr` == (`LAST_ADDR` & ~1) → DONE;
    - otherwise `rom_addr` += 2 → FETCH.
  - **DONE**: `done`=1, `cpu_hold`=0, `boot`=0. `start`=1 → FETCH with `rom_addr`=0 and `done` cleared.
- Address arithmetic is unsigned ADDR_W. The end compare happens before the increment, so `LAST_ADDR`=254 terminates without wrapping to 0.
- `start` is ignored in FETCH and WRITE.
- `ram_wdata` is stable for the whole WRITE state, including stalls.

## Timing
- Reset values:
  - 0: `boot`, `rom_addr`, `ram_addr`, `ram_wdata`, `ram_we`, `busy`, `done`.
  - 1: `cpu_hold`.
  - State: IDLE.
- Asserting `rst_n` mid-copy drops `boot` and `ram_we` immediately (asynchronously). A partial image stays in RAM, and a new `start` is required.
- Latency from `start` sampled high to the first `ram_we` is 2 cycles.
- Each word takes at least 2 cycles (FETCH + WRITE), plus 1 cycle per `ram_ready`=0 stall cycle.
- With `ram_ready` tied high, a full copy of N = `LAST_ADDR`/2 + 1 words takes 2N cycles. `done` rises on the cycle after the last accepted write (default N=24 → `done` rises 49 cycles after `start`).
- `boot` is never high in IDLE or DONE, so the bus is never driven by the ROM outside a copy.

## Structure
- Package `boot_pkg`:
  - `boot_state_t` enum {IDLE, FETCH, WRITE, DONE};
  - `ADDR_W`/`WORD_W` defaults derived from `ADDR_SIZE`/`WORD_SIZE`.
- Single module with no sub-module. The address counter and end compare are inline.
- Integration: `boot` connects directly to the ROM's boot input, and `rom_addr` feeds the ROM address through the top-level address mux while `busy`=1.

## Test plan
- **Reset**: `rst_n`=0 → `boot`=0, `ram_we`=0, `done`=0, `cpu_hold`=1, `rom_addr`=0.
- **Full copy**: ROM model with default image, `ram_ready`=1, `start` pulse → 24 writes at addresses 0,2,…,46. RAM[40]=0, RAM[46]=2. `done` rises 49 cycles after `start`; `boot` falls on the same cycle.
- **Backpressure**: `ram_ready` low for 3 cycles on the write to address 12 → `ram_we` held and `ram_wdata` unchanged for 4 cycles. No duplicate or skipped address; total is 52 cycles.
- **Boundary**: `LAST_ADDR`=254 → last write at 254, then DONE with `rom_addr`=254 (no wrap to 0). `LAST_ADDR`=47 → behaves as 46.
- **Mid-copy reset**: `rst_n` low while in WRITE at address 20 → `boot`/`ram_we` go to 0 within the same cycle. A new `start` restarts at address 0.
- **Start handling**: `start` held high during the copy has no effect. `start` in DONE → `done` clears and a second identical copy runs.
